dec_scan: RTL and testbench

DEC_SCAN -- requirements
Module: dec_scan

---
 rtl/dec_scan.sv | 99 +++++++++
 tb/tb_dec_scan.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dec_scan.sv
// dec_scan: registered one-hot decoder with manual select and prescaled auto-scan.
// Optional anti-ghosting blanking when DEC_SCAN_BLANK_EN is defined.
module dec_scan #(
  parameter int N        = 2,
  parameter int PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic [N-1:0]   a,
  output logic [0:2**N-1] s,
  output logic [N-1:0]   idx,
  output logic           wrap
);

  localparam int M  = 2**N;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [N-1:0]  IMAX = {N{1'b1}};

  logic [0:M-1]  s_q, s_d;
  logic [N-1:0]  idx_q, idx_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          mode_q;

  logic          mode_chg;
  logic [PW-1:0] pre_cur;
  logic          step;

  function automatic logic [0:M-1] onehot(input logic [N-1:0] v);
    logic [0:M-1] o;
    o    = '0;
    o[v] = 1'b1;
    return o;
  endfunction

  // a mode change restarts the count, and that edge counts as prescaler 0
  assign mode_chg = mode ^ mode_q;
  assign pre_cur  = mode_chg ? '0 : pre_q;
  assign step     = (pre_cur == PMAX);

  always_comb begin
    s_d    = s_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    pre_d  = pre_q;
    unique case (1'b1)
      !en: begin
        s_d   = '0;
        pre_d = pre_cur;
      end
      en && !mode: begin
        idx_d = a;
        s_d   = onehot(a);
        pre_d = '0;
      end
      en && mode: begin
        if (step) begin
          idx_d  = idx_q + N'(1);
          pre_d  = '0;
          wrap_d = (idx_q == IMAX);
        end else begin
          pre_d  = pre_cur + PW'(1);
        end
        s_d = onehot(idx_d);
`ifdef DEC_SCAN_BLANK_EN
        if (step) s_d = '0;
`else
`endif
      end
      default: begin
        s_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      pre_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      pre_q  <= pre_d;
      mode_q <= mode;
    end
  end

  assign s    = s_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// tb_dec_scan: table-driven check of dec_scan (N=2) at PRESCALE 4 and 1.
// Blank-build expectations follow DEC_SCAN_BLANK_EN.
module tb_dec_scan;

`ifdef DEC_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] a = 2'd0;
  logic [0:3] s, s1;
  logic [1:0] idx, idx1;
  logic       wrap, wrap1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dec_scan #(.N(2), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
    .s(s), .idx(idx), .wrap(wrap)
  );

  dec_scan #(.N(2), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
    .s(s1), .idx(idx1), .wrap(wrap1)
  );

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] a;
    logic [0:3] s;
    logic [1:0] idx;
    logic       w;
    logic       bz;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [0:3] oh(input int i);
    logic [0:3] o;
    o = '0;
    o[i] = 1'b1;
    return o;
  endfunction

  task automatic add(input logic e, input logic m, input logic [1:0] av,
                     input logic [0:3] sv, input logic [1:0] iv,
                     input logic w, input logic bz);
    vec_t v;
    v.en = e; v.mode = m; v.a = av;
    v.s = sv; v.idx = iv; v.w = w; v.bz = bz;
    tbl.push_back(v);
  endtask

  initial begin
    logic [0:3] es;
    // manual sweep
    add(1, 0, 0, 4'b1000, 0, 0, 0);
    add(1, 0, 1, 4'b0100, 1, 0, 0);
    add(1, 0, 2, 4'b0010, 2, 0, 0);
    add(1, 0, 3, 4'b0001, 3, 0, 0);
    // switch to scan at idx 3: continues 3 -> 0 with wrap
    add(1, 1, 0, 4'b0001, 3, 0, 0);
    add(1, 1, 0, 4'b0001, 3, 0, 0);
    add(1, 1, 0, 4'b0001, 3, 0, 0);
    add(1, 1, 0, 4'b1000, 0, 1, 1);
    add(1, 1, 0, 4'b1000, 0, 0, 0);
    add(1, 1, 0, 4'b1000, 0, 0, 0);
    add(1, 1, 0, 4'b1000, 0, 0, 0);
    add(1, 1, 0, 4'b0100, 1, 0, 1);
    add(1, 1, 0, 4'b0100, 1, 0, 0);
    add(1, 1, 0, 4'b0100, 1, 0, 0);
    add(1, 1, 0, 4'b0100, 1, 0, 0);
    add(1, 1, 0, 4'b0010, 2, 0, 1);
    add(1, 1, 0, 4'b0010, 2, 0, 0);
    // freeze at idx 2, prescaler 1, for 5 clocks
    for (int i = 0; i < 5; i++) add(0, 1, 0, 4'b0000, 2, 0, 0);
    add(1, 1, 0, 4'b0010, 2, 0, 0);
    add(1, 1, 0, 4'b0010, 2, 0, 0);
    add(1, 1, 0, 4'b0001, 3, 0, 1);
    add(1, 1, 0, 4'b0001, 3, 0, 0);
    // mode toggles while disabled: frozen, but prescaler restarts
    add(0, 0, 0, 4'b0000, 3, 0, 0);
    add(0, 1, 0, 4'b0000, 3, 0, 0);
    add(1, 1, 0, 4'b0001, 3, 0, 0);
    add(1, 1, 0, 4'b0001, 3, 0, 0);
    add(1, 1, 0, 4'b0001, 3, 0, 0);
    add(1, 1, 0, 4'b1000, 0, 1, 1);
    add(1, 1, 0, 4'b1000, 0, 0, 0);

    // asynchronous reset with no clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s", s, 0);
    chk("rst_idx", idx, 0);
    chk("rst_wrap", wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk);
      en = tbl[k].en; mode = tbl[k].mode; a = tbl[k].a;
      @(posedge clk);
      #1;
      es = (BLANK && tbl[k].bz) ? 4'b0000 : tbl[k].s;
      chk($sformatf("v%0d_s", k), s, es);
      chk($sformatf("v%0d_idx", k), idx, tbl[k].idx);
      chk($sformatf("v%0d_wrap", k), wrap, tbl[k].w);
    end

    // reset mid-scan abandons the step in progress
    @(negedge clk);
    en = 1'b1; mode = 1'b0; a = 2'd2;
    @(posedge clk); #1;
    chk("pre_rst_idx", idx, 2);
    @(negedge clk);
    mode = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_s", s, 0);
    chk("mid_rst_idx", idx, 0);
    chk("mid_rst_wrap", wrap, 0);
    chk("mid_rst_idx1", idx1, 0);
    #1 rst_n = 1'b1;

    // first step PRESCALE edges after release; PRESCALE=1 steps every edge
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      es = (k == 4) ? (BLANK ? 4'b0000 : 4'b0100) : 4'b1000;
      chk($sformatf("rel%0d_s", k), s, es);
      chk($sformatf("rel%0d_idx", k), idx, (k == 4) ? 1 : 0);
      chk($sformatf("rel%0d_wrap", k), wrap, 0);
      es = BLANK ? 4'b0000 : oh(k % 4);
      chk($sformatf("p1_%0d_s", k), s1, es);
      chk($sformatf("p1_%0d_idx", k), idx1, k % 4);
      chk($sformatf("p1_%0d_wrap", k), wrap1, (k == 4) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
